// File: rtl/qsys_block_led_pwm_pkg.sv
// qsys_block_led_pwm_pkg: register map, reset values and read mux for the LED PWM block.
package qsys_block_led_pwm_pkg;

    localparam logic [1:0] ADDR_BRIGHT = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_HALF   = 2'd2;
    localparam logic [1:0] ADDR_STAT   = 2'd3;

    localparam logic [7:0] BRIGHT_RST = 8'hFF;

    typedef struct packed {
        logic [7:0]  brightness;
        logic [7:0]  blink_mask;
        logic [15:0] half_period;
    } cfg_t;

    localparam cfg_t CFG_RST = '{brightness: BRIGHT_RST, blink_mask: 8'h00, half_period: 16'h0000};

    function automatic logic [31:0] read_mux(input logic [1:0] addr, input cfg_t cfg,
                                             input logic phase, input logic [7:0] pat);
        return addr == ADDR_BRIGHT ? {24'b0, cfg.brightness} :
               addr == ADDR_MASK   ? {24'b0, cfg.blink_mask} :
               addr == ADDR_HALF   ? {16'b0, cfg.half_period} :
                                     {23'b0, phase, pat};
    endfunction

endpackage

// File: rtl/qsys_block_led_pwm_timebase.sv
// qsys_block_led_pwm_timebase: clock prescaler and free-running PWM counter.
module qsys_block_led_pwm_timebase #(
    parameter int PRESCALE = 50,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                tick_o,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                period_start_o
);

    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]       prescale_cnt_q, prescale_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        tick_o         = prescale_cnt_q == PS_MAX;
        prescale_cnt_d = tick_o ? '0 : prescale_cnt_q + PW'(1);
        pwm_cnt_d      = tick_o ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        period_start_o = tick_o && (&pwm_cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_cnt_q <= '0;
            pwm_cnt_q      <= '0;
        end else begin
            prescale_cnt_q <= prescale_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
        end
    end

    assign pwm_cnt_o = pwm_cnt_q;

endmodule

// File: rtl/qsys_block_led_pwm.sv
// qsys_block_led_pwm: LED driver with global PWM brightness and per-LED blink,
// configured over Avalon-MM; pattern and settings are shadowed at period boundaries.
module qsys_block_led_pwm
    import qsys_block_led_pwm_pkg::*;
#(
    parameter int LED_WIDTH = 8,
    parameter int PRESCALE  = 50,
    parameter int PWM_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [LED_WIDTH-1:0] led_pattern,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [LED_WIDTH-1:0] led_out
);

    logic                 tick, period_start;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 wr_bright, wr_mask, wr_half, blink_wrap, blink_hold;
    cfg_t                 cfg_q, cfg_d;
    logic [15:0]          blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [LED_WIDTH-1:0] pattern_act_q, pattern_act_d;
    logic [7:0]           duty_act_q, duty_act_d;
    logic [LED_WIDTH-1:0] led_out_q, led_out_d;
    logic                 unused;

    qsys_block_led_pwm_timebase #(
        .PRESCALE(PRESCALE),
        .PWM_BITS(PWM_BITS)
    ) u_timebase (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick_o        (tick),
        .pwm_cnt_o     (pwm_cnt),
        .period_start_o(period_start)
    );

    assign unused = ^{tick, writedata[31:16]};

    always_comb begin
        wr_bright = chipselect && !write_n && address == ADDR_BRIGHT;
        wr_mask   = chipselect && !write_n && address == ADDR_MASK;
        wr_half   = chipselect && !write_n && address == ADDR_HALF;
        cfg_d.brightness  = wr_bright ? writedata[7:0] : cfg_q.brightness;
        cfg_d.blink_mask  = wr_mask ? writedata[7:0] : cfg_q.blink_mask;
        cfg_d.half_period = wr_half ? writedata[15:0] : cfg_q.half_period;
        // A half_period write restarts the blink cadence, even on a period boundary
        blink_hold    = wr_half || (period_start && cfg_q.half_period == 16'd0);
        blink_wrap    = blink_cnt_q == cfg_q.half_period - 16'd1;
        blink_cnt_d   = blink_hold ? 16'd0 : !period_start ? blink_cnt_q :
                        blink_wrap ? 16'd0 : blink_cnt_q + 16'd1;
        blink_phase_d = blink_hold ? 1'b0 : (period_start && blink_wrap) ? ~blink_phase_q :
                        blink_phase_q;
        pattern_act_d = period_start ? led_pattern : pattern_act_q;
        duty_act_d    = period_start ? cfg_q.brightness : duty_act_q;
        led_out_d     = pattern_act_q & {LED_WIDTH{pwm_cnt < duty_act_q}} &
                        ~(cfg_q.blink_mask & {LED_WIDTH{blink_phase_q}});
        readdata      = read_mux(address, cfg_q, blink_phase_q, pattern_act_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q         <= CFG_RST;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pattern_act_q <= '0;
            duty_act_q    <= '0;
            led_out_q     <= '0;
        end else begin
            cfg_q         <= cfg_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pattern_act_q <= pattern_act_d;
            duty_act_q    <= duty_act_d;
            led_out_q     <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: doc/qsys_block_led_pwm.md
Name: qsys_block_led_pwm

Overview:
- Downstream consumer of the 8-bit LED PIO output. Drives the physical LED pins.
- Adds global PWM brightness control and per-LED blink. Both are configured through a small Avalon-MM slave on the same Qsys fabric.
- The incoming pattern and the settings are sampled only at PWM-period boundaries, so the LEDs never glitch mid-period.

Parameters:
- LED_WIDTH, 8, number of LEDs; fixed at 8 for register layout.
- PRESCALE, 50, clk cycles per PWM tick (>=1); at 50 MHz, one PWM period is 256 us.
- PWM_BITS, 8, PWM counter width; one period is 2^PWM_BITS ticks.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- led_pattern  in  8  LED on/off pattern from the upstream PIO
- address  in  2  Avalon-MM register select
- chipselect  in  1  Avalon-MM select
- write_n  in  1  Avalon-MM write strobe, active-low
- writedata  in  32  Avalon-MM write data
- readdata  out  32  Avalon-MM read data; combinational, 0 wait states
- led_out  out  8  registered drive to the LED pins, 1 = lit

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - brightness = 8'hFF
  - blink_mask = 0, half_period = 0
  - prescale_cnt = 0, pwm_cnt = 0, blink_cnt = 0, blink_phase = 0
  - pattern_act = 0, duty_act = 0
  - led_out = 0
- Register map (write when chipselect && !write_n):
  - addr 0: brightness <= writedata[7:0]
  - addr 1: blink_mask <= writedata[7:0]
  - addr 2: half_period <= writedata[15:0]; same cycle clears blink_cnt and blink_phase.
  - addr 3: read-only; writes are ignored.
- Reads: readdata is zero-extended.
  - addr 0 returns brightness.
  - addr 1 returns blink_mask.
  - addr 2 returns half_period.
  - addr 3 returns {23'b0, blink_phase, pattern_act}.
- Timebase:
  - prescale_cnt counts 0..PRESCALE-1 and wraps; tick = (prescale_cnt == PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
  - pwm_cnt increments on tick and wraps 255->0.
  - period_start = tick && pwm_cnt == 255.
- At period_start:
  - pattern_act <= led_pattern and duty_act <= brightness. Values are sampled at that edge, so a write in the same cycle is not captured; it takes effect next period.
  - If half_period != 0: blink_cnt increments; when blink_cnt == half_period-1, blink_cnt <= 0 and blink_phase toggles.
  - If half_period == 0: blink_cnt and blink_phase are held at 0.
  - A write to addr 2 coinciding with period_start wins: counters are cleared.
- Output, registered every clk: led_out[i] <= pattern_act[i] & (pwm_cnt < duty_act) & ~(blink_mask[i] & blink_phase).
  - Latency is 1 clk from the pwm_cnt/shadow state.
  - duty 0 keeps the LED fully off; duty 255 gives on-time 255/256.
  - Latency from a led_pattern change to led_out is at most one PWM period + 1 clk.
- Mid-operation reset: everything returns to reset values immediately; led_out goes to 0 asynchronously.
- led_pattern is synchronous to clk; no synchronizer is needed.

Decomposition:
- Package qsys_block_led_pwm_pkg holds:
  - register address constants ADDR_BRIGHT=0, ADDR_MASK=1, ADDR_HALF=2, ADDR_STAT=3
  - reset constant BRIGHT_RST=8'hFF
- One sub-module, qsys_block_led_pwm_timebase: prescaler plus pwm_cnt. Outputs tick, pwm_cnt and period_start.
- Register file, blink logic and output stage stay in the top level.

Test Plan:
- Reset (PRESCALE=1):
  - Stimulus: hold reset_n=0, then release.
  - Required: led_out=0; readdata addr0 = 32'h000000FF; addr1, addr2 and addr3 read 0.
- Pattern latch (PRESCALE=1, brightness 255):
  - Stimulus: led_pattern=8'hA5 applied mid-period.
  - Required: led_out stays 0 until the first period_start; then 8'hA5 for 255 clks and 0 for 1 clk per 256-clk period.
- Duty (PRESCALE=1):
  - Stimulus: write addr0=64, led_pattern=8'hFF.
  - Required: from the next period, led_out=8'hFF for exactly 64 clks then 0 for 192; repeats.
  - Stimulus: write addr0=0.
  - Required: led_out stays 0 from the following period.
- Blink (PRESCALE=1, brightness 255, pattern 8'hFF):
  - Stimulus: addr1=8'h0F, addr2=2.
  - Required: led_out bits[3:0] are suppressed for 2 periods out of every 4; bits[7:4] are unaffected.
  - Required: addr3 bit8 toggles every 512 clks.
- Simultaneous write (PRESCALE=1):
  - Stimulus: write addr0=16 exactly on the period_start clk.
  - Required: the old duty applies for that period; 16-clk on-time starts one period later.
  - Stimulus: write addr2 on a period_start.
  - Required: blink_phase reads 0 afterwards.
- Reset mid-blink (PRESCALE=3):
  - Stimulus: assert reset_n=0 while blink_phase=1.
  - Required: led_out=0 with no clk edge; after release, the period is 768 clks and the registers hold reset values.
